// File: rtl/multicycle_controller.sv
// Multi-cycle control sequencer for the shared-memory datapath: FETCH/DECODE/EXEC/MEM/WB walk,
// memory request handshake with timeout, illegal-opcode trap. Optional MCC_RETIRE_CNT_EN adds retired_count.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        alu_src,
  output logic        reg_dst,
  output logic [1:0]  alu_op,
  output logic        mem_to_reg,
  output logic        illegal_op,
  output logic        mem_fault,
  output logic [3:0]  state
`ifdef MCC_RETIRE_CNT_EN
  ,
  output logic [15:0] retired_count
`endif
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_ADDR = 4'd2,
    S_MEM_RD    = 4'd3,
    S_WB_MEM    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_WB_R      = 4'd8,
    S_JUMP      = 4'd9,
    S_WB_I      = 4'd10,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_R     = 6'b100010;
  localparam logic [5:0] OP_NANDI = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Width never drops to zero so MEM_TIMEOUT=0 still elaborates; the counter is then idle.
  localparam int          CW     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit          TMO_EN = (MEM_TIMEOUT != 0);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  state_t          state_r;
  state_t          nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;
  logic            store_r;
  logic            illegal_r;
  logic            fault_r;
  logic            set_ill_s;
  logic            set_flt_s;
  logic            mem_state_s;
  logic            timeout_s;

  // Timeout fires on the MEM_TIMEOUT-th consecutive idle cycle; a ready in that cycle still wins.
  always_comb begin
    if (TMO_EN) begin
      timeout_s = (cnt_r == LIMIT);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next-state decode, trap flags and memory-state qualifier.
  always_comb begin
    nxt_s       = state_r;
    set_ill_s   = 1'b0;
    set_flt_s   = 1'b0;
    mem_state_s = 1'b0;
    case (state_r)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        mem_state_s = 1'b1;
        if (mem_ready) begin
          case (state_r)
            S_FETCH:  nxt_s = S_DECODE;
            S_MEM_RD: nxt_s = S_WB_MEM;
            default:  nxt_s = S_FETCH;
          endcase
        end else if (timeout_s) begin
          nxt_s     = S_HALT;
          set_flt_s = 1'b1;
        end else begin
          nxt_s = state_r;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt_s = S_EXEC_ADDR;
          OP_R:         nxt_s = S_EXEC_R;
          OP_NANDI:     nxt_s = S_EXEC_I;
          OP_J:         nxt_s = S_JUMP;
          default: begin
            nxt_s     = S_HALT;
            set_ill_s = 1'b1;
          end
        endcase
      end
      S_EXEC_ADDR: begin
        if (store_r) begin
          nxt_s = S_MEM_WR;
        end else begin
          nxt_s = S_MEM_RD;
        end
      end
      S_EXEC_R: nxt_s = S_WB_R;
      S_EXEC_I: nxt_s = S_WB_I;
      S_WB_MEM, S_WB_R, S_WB_I, S_JUMP: nxt_s = S_FETCH;
      S_HALT:   nxt_s = S_HALT;
      default:  nxt_s = S_HALT;
    endcase
  end

  // Counter restarts on every state change, so each memory state begins its window at zero.
  always_comb begin
    if (nxt_s != state_r) begin
      cnt_nxt_s = '0;
    end else if (TMO_EN && mem_state_s && !mem_ready) begin
      cnt_nxt_s = cnt_r + CW'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State register, timeout counter, lw/sw latch and sticky traps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      cnt_r     <= '0;
      store_r   <= 1'b0;
      illegal_r <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= nxt_s;
      cnt_r     <= cnt_nxt_s;
      store_r   <= (state_r == S_DECODE) ? (opcode == OP_SW) : store_r;
      illegal_r <= illegal_r | set_ill_s;
      fault_r   <= fault_r | set_flt_s;
    end
  end

  // Control decode: Moore on state except ir_write/pc_write in FETCH; all zero while in reset.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    mem_fault  = 1'b0;
    state      = 4'd0;
    if (rst_n) begin
      state      = state_r;
      illegal_op = illegal_r;
      mem_fault  = fault_r;
      case (state_r)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC_ADDR: alu_src = 1'b1;
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_WB_MEM: reg_write = 1'b1;
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_EXEC_R: alu_op = 2'b10;
        S_WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_EXEC_I: begin
          alu_src = 1'b1;
          alu_op  = 2'b01;
        end
        S_WB_I: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end
        default: state = state_r;
      endcase
    end else begin
      state = 4'd0;
    end
  end

`ifdef MCC_RETIRE_CNT_EN
  logic [15:0] ret_r;
  logic        retire_s;

  // An instruction retires in its last cycle; a store retires when its write is accepted.
  always_comb begin
    case (state_r)
      S_WB_MEM, S_WB_R, S_WB_I, S_JUMP: retire_s = 1'b1;
      S_MEM_WR: retire_s = mem_ready;
      default:  retire_s = 1'b0;
    endcase
  end

  // Retirement counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ret_r <= 16'd0;
    end else if (retire_s) begin
      ret_r <= ret_r + 16'd1;
    end else begin
      ret_r <= ret_r;
    end
  end

  // Output gated to zero while reset is held.
  always_comb begin
    if (rst_n) begin
      retired_count = ret_r;
    end else begin
      retired_count = 16'd0;
    end
  end
`endif

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer that replaces single-cycle decode for the shared-memory datapath. It takes the instruction opcode and walks the datapath through fetch, decode, execute, memory and write-back states, one state per clock. It drives the same control set as the combinational decoder: regWrite/ALUSrc/ALUOp/MemRead/MemWrite/MemtoReg/PCSrc/RegDst, using the same encodings. It also owns the memory request/ready handshake, a memory timeout, and an illegal-opcode trap.

## Interface
- MEM_TIMEOUT, 16: cycles allowed for mem_ready per memory request; 0 disables the timeout.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- opcode  input  6  instruction opcode from the instruction register; sampled only in DECODE.
- mem_ready  input  1  memory completion; meaningful only while mem_req=1.
- mem_req  output  1  memory access request.
- mem_we  output  1  write qualifier for mem_req (store).
- iord  output  1  memory address select: 0=PC (fetch), 1=ALU result (data).
- ir_write  output  1  load the instruction register.
- pc_write  output  1  update the PC.
- pc_src  output  1  0=PC+4, 1=jump target.
- reg_write, alu_src, reg_dst  output  1 each  same meaning as the single-cycle decoder.
- alu_op  output  2  00=add (address), 10=R-type funct, 01=nand-immediate.
- mem_to_reg  output  1  0=memory data, 1=ALU result.
- illegal_op  output  1  sticky: undecodable opcode.
- mem_fault  output  1  sticky: memory timeout.
- state  output  4  current state, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC_ADDR=2, MEM_RD=3, WB_MEM=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, WB_R=8, JUMP=9, WB_I=10, HALT=15. Unused codes go to HALT.
- FETCH: mem_req=1, iord=0. In the cycle with mem_ready=1, also assert ir_write=1 and pc_write=1 (pc_src=0), then go to DECODE.
- DECODE: all controls are 0. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → EXEC_ADDR
  - 100010 (R-type) → EXEC_R
  - 001110 (nandi) → EXEC_I
  - 000010 (jump) → JUMP
  - any other opcode → HALT, and set illegal_op
- EXEC_ADDR: alu_src=1, alu_op=00. Next state is MEM_RD for lw, MEM_WR for sw. The lw/sw distinction is latched at DECODE.
- MEM_RD: mem_req=1, iord=1; wait for ready, then WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; wait for ready, then FETCH.
- EXEC_R: alu_src=0, alu_op=10, then WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=1, then FETCH.
- EXEC_I: alu_src=1, alu_op=01, then WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- JUMP: pc_write=1, pc_src=1, then FETCH.
- HALT: all controls are 0; stays in HALT until reset.
- Every output not listed for a state is 0 in that state.
- Handshake:
  - mem_req holds high from entry into a memory state until the cycle mem_ready=1.
  - mem_req drops on the following cycle.
  - mem_ready with mem_req=0 is ignored.
- Timeout counter:
  - Width is clog2(MEM_TIMEOUT+1). It clears on entry to FETCH, MEM_RD and MEM_WR.
  - It increments on each memory-state cycle with mem_ready=0.
  - If MEM_TIMEOUT consecutive cycles pass with mem_ready=0, the next state is HALT and mem_fault is set.
  - mem_ready arriving in the MEM_TIMEOUT-th cycle still succeeds.

## Timing
- Reset:
  - While rst_n=0, all outputs are forced to 0 combinationally.
  - At the first rising edge with rst_n=0: state=FETCH; illegal_op, mem_fault, the counter and the lw/sw latch clear.
  - The first cycle with rst_n=1 asserts mem_req.
- Reset mid-transaction abandons the access. mem_req is 0 in the reset cycle; no write-back occurs.
- Latency with zero-wait memory (ready in the first request cycle):
  - R-type and nandi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - jump: 3 cycles.
  - Each wait cycle adds 1.
- ir_write and pc_write in FETCH are Mealy on mem_ready. All other outputs decode from state only.

## Configuration
- MCC_RETIRE_CNT_EN defined:
  - Adds output retired_count[15:0], reset to 0.
  - Increments by 1 on the final cycle of each instruction: WB_MEM, MEM_WR with ready, WB_R, WB_I, JUMP.
  - Wraps 0xFFFF → 0x0000.
- MCC_RETIRE_CNT_EN undefined: the port and its logic are absent.

## Test plan
- Reset, then opcode=100010 with mem_ready tied 1 → state sequence 0,1,6,8,0. reg_write=1 with reg_dst=1, mem_to_reg=1 only in cycle 4.
- lw (100011), mem_ready delayed 3 cycles in MEM_RD → mem_req held high exactly 3 cycles then low; WB_MEM has reg_write=1, mem_to_reg=0; 7 cycles total.
- sw (101011) then jump (000010) → MEM_WR has mem_we=1, iord=1, reg_write never asserts; JUMP has pc_write=1, pc_src=1.
- Opcode 111111 → HALT (state=15), illegal_op=1 held for 20 cycles; rst_n=0 for 1 cycle clears it and returns to FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → mem_req high 4 cycles, then HALT with mem_fault=1. Repeat with ready in cycle 4 → DECODE, no fault.
- With MCC_RETIRE_CNT_EN defined, preload near wrap by running 65537 zero-wait R-type instructions → retired_count=0x0001.
